// File: rtl/radix4_mult_pkg.sv
// rtl/radix4_mult_pkg.sv - shared states and sizing helpers for the radix-4 serial multiplier
package radix4_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CARRY = 2'd2,
    HOLD  = 2'd3
  } acc_state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DIGITS        = DEFAULT_WIDTH / 2;
  localparam int CNT_W         = $clog2(DIGITS + 1);

  function automatic int digits_f(input int width);
    return width / 2;
  endfunction

  function automatic int cnt_width_f(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/radix4_acc_datapath.sv
// rtl/radix4_acc_datapath.sv - acc/low registers, digit adder, 2-bit shifter and final carry fold
// Optional RADIX4_ACC_ERR_EN adds the ovf_o flag used by the top's error tracking.
module radix4_acc_datapath
  import radix4_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               last_i,
  input  logic               fold_i,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH+1:0]   pp_i,
  input  logic               pp_neg_i,
  input  logic               final_carry_i,
  output logic [2*WIDTH-1:0] product_o
`ifdef RADIX4_ACC_ERR_EN
  ,
  output logic               ovf_o
`endif
);

  logic [WIDTH-1:0]        x_q;
  logic [WIDTH-1:0]        low_q;
  logic [WIDTH+1:0]        acc_q;
  logic                    fc_q;
  logic [2*WIDTH-1:0]      product_q;
  logic signed [WIDTH+2:0] sum;
  logic [WIDTH+1:0]        acc_d;
  logic [WIDTH-1:0]        high;

  assign sum = $signed({acc_q[WIDTH+1], acc_q})
             + $signed({pp_i[WIDTH+1], pp_i})
             + $signed({{(WIDTH+2){1'b0}}, pp_neg_i});

  // Arithmetic shift by two: the sign bit of the wide sum refills the top.
  assign acc_d = {sum[WIDTH+2], sum[WIDTH+2:2]};
  assign high  = acc_q[WIDTH-1:0] + (fc_q ? x_q : '0);

`ifdef RADIX4_ACC_ERR_EN
  // The adder result no longer fits the WIDTH+2 accumulator format.
  assign ovf_o = sum[WIDTH+2] != sum[WIDTH+1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      low_q     <= '0;
      acc_q     <= '0;
      fc_q      <= 1'b0;
      product_q <= '0;
    end else begin
      if (load_i) begin
        x_q   <= x_i;
        low_q <= '0;
        acc_q <= '0;
        fc_q  <= 1'b0;
      end else if (step_i) begin
        low_q <= {sum[1:0], low_q[WIDTH-1:2]};
        acc_q <= acc_d;
        if (last_i) fc_q <= final_carry_i;
      end
      if (fold_i) product_q <= {high, low_q};
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/radix4_pp_accumulator.sv
// rtl/radix4_pp_accumulator.sv - digit sequencing and product handshake for the radix-4 multiplier
// Optional RADIX4_ACC_ERR_EN adds a sticky err output.
module radix4_pp_accumulator
  import radix4_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic               pp_valid,
  output logic               pp_ready,
  input  logic [WIDTH+1:0]   pp,
  input  logic               pp_neg,
  input  logic               final_carry,
  output logic               busy,
  output logic [2*WIDTH-1:0] product,
  output logic               product_valid,
  input  logic               product_ready
`ifdef RADIX4_ACC_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int N_DIGITS  = digits_f(WIDTH);
  localparam int CNT_WIDTH = cnt_width_f(WIDTH);

  acc_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 load, step, last, fold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    fold    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (pp_valid) begin
          step    = 1'b1;
          count_d = count_q + CNT_WIDTH'(1);
          if (count_q == CNT_WIDTH'(N_DIGITS - 1)) begin
            last    = 1'b1;
            state_d = CARRY;
          end
        end
      end
      CARRY: begin
        fold    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (product_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pp_ready      = state_q == ACCUM;
  assign busy          = state_q != IDLE;
  assign product_valid = state_q == HOLD;

`ifdef RADIX4_ACC_ERR_EN
  logic ovf;
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (pp_valid && state_q != ACCUM) err_d = 1'b1;
    if (start && state_q != IDLE)     err_d = 1'b1;
    if (step && ovf)                  err_d = 1'b1;
    if (load)                         err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`endif

  radix4_acc_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk           (clk),
    .reset         (reset),
    .load_i        (load),
    .step_i        (step),
    .last_i        (last),
    .fold_i        (fold),
    .x_i           (x),
    .pp_i          (pp),
    .pp_neg_i      (pp_neg),
    .final_carry_i (final_carry),
    .product_o     (product)
`ifdef RADIX4_ACC_ERR_EN
    ,
    .ovf_o         (ovf)
`endif
  );

endmodule

// File: tb/tb_radix4_pp_accumulator.sv
// tb/tb_radix4_pp_accumulator.sv - directed vector bench for radix4_pp_accumulator (WIDTH=8)
module tb_radix4_pp_accumulator;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0]         x;
    logic [3:0][WIDTH+1:0]    pp;
    logic [3:0]               neg;
    logic                     fc;
    logic [2*WIDTH-1:0]       exp;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   x = '0;
  logic               pp_valid = 1'b0;
  logic [WIDTH+1:0]   pp = '0;
  logic               pp_neg = 1'b0;
  logic               final_carry = 1'b0;
  logic               product_ready = 1'b0;
  logic               pp_ready;
  logic               busy;
  logic [2*WIDTH-1:0] product;
  logic               product_valid;
`ifdef RADIX4_ACC_ERR_EN
  logic               err;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  radix4_pp_accumulator #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .x             (x),
    .pp_valid      (pp_valid),
    .pp_ready      (pp_ready),
    .pp            (pp),
    .pp_neg        (pp_neg),
    .final_carry   (final_carry),
    .busy          (busy),
    .product       (product),
    .product_valid (product_valid),
    .product_ready (product_ready)
`ifdef RADIX4_ACC_ERR_EN
    ,
    .err           (err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input int gap, input int hold, input string tag);
    int cyc;
    int n;
    start = 1'b1;
    x     = v.x;
    step();
    start = 1'b0;
    x     = '0;
    cyc   = 1;
    check({tag, " busy/pp_ready"}, {30'd0, busy, pp_ready}, 32'h3);
`ifdef RADIX4_ACC_ERR_EN
    check({tag, " err cleared"}, {31'd0, err}, 32'd0);
`endif
    for (int d = 0; d < 4; d++) begin
      for (int g = 0; g < gap; g++) begin
        pp_valid = 1'b0;
        pp       = 10'h155;
        pp_neg   = 1'b1;
        step();
        cyc++;
      end
      pp_valid    = 1'b1;
      pp          = v.pp[d];
      pp_neg      = v.neg[d];
      final_carry = (d == 3) ? v.fc : ~v.fc;
      step();
      cyc++;
    end
    pp_valid    = 1'b0;
    pp          = '0;
    pp_neg      = 1'b0;
    final_carry = 1'b0;
    n = 0;
    while (!product_valid && n < 20) begin
      step();
      cyc++;
      n++;
    end
    check({tag, " latency"}, cyc, 6 + 4 * gap);
    check({tag, " product"}, {16'd0, product}, {16'd0, v.exp});
    for (int h = 0; h < hold; h++) begin
      start = (h == 2);
      step();
      check({tag, " hold valid"}, {31'd0, product_valid}, 32'd1);
      check({tag, " hold product"}, {16'd0, product}, {16'd0, v.exp});
    end
    start = 1'b0;
`ifdef RADIX4_ACC_ERR_EN
    if (hold > 2) check({tag, " err on ignored start"}, {31'd0, err}, 32'd1);
`endif
    product_ready = 1'b1;
    step();
    product_ready = 1'b0;
    check({tag, " idle after ready"}, {30'd0, busy, product_valid}, 32'd0);
    check({tag, " product kept"}, {16'd0, product}, {16'd0, v.exp});
  endtask

  initial begin
    // 255*255: first digit is -x via ~x + 1, final carry folds x into the high half
    vecs[0] = '{x: 8'hFF, pp: {10'h000, 10'h000, 10'h000, 10'h300}, neg: 4'b0001, fc: 1'b1, exp: 16'hFE01};
    vecs[1] = '{x: 8'h03, pp: {10'h000, 10'h000, 10'h000, 10'h006}, neg: 4'b0000, fc: 1'b0, exp: 16'h0006};
    vecs[2] = '{x: 8'h00, pp: {10'h000, 10'h000, 10'h000, 10'h000}, neg: 4'b0000, fc: 1'b0, exp: 16'h0000};
    vecs[3] = '{x: 8'hFF, pp: {10'h000, 10'h000, 10'h000, 10'h1FE}, neg: 4'b0000, fc: 1'b0, exp: 16'h01FE};
    vecs[4] = '{x: 8'h10, pp: {10'h000, 10'h000, 10'h3EF, 10'h020}, neg: 4'b0010, fc: 1'b1, exp: 16'h0FE0};

    step();
    step();
    check("reset outputs", {13'd0, pp_ready, busy, product_valid, product}, 32'd0);
    reset = 1'b0;
    step();
    check("idle after reset", {30'd0, busy, pp_ready}, 32'd0);

    for (int i = 0; i < 5; i++) run(vecs[i], 0, 0, $sformatf("vec%0d", i));

    run(vecs[0], 0, 5, "hold");
    run(vecs[4], 2, 0, "gap");

    start = 1'b1;
    x     = 8'hFF;
    step();
    start    = 1'b0;
    pp_valid = 1'b1;
    pp       = 10'h300;
    pp_neg   = 1'b1;
    step();
    pp     = '0;
    pp_neg = 1'b0;
    step();
    pp_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("mid-run reset outputs", {13'd0, pp_ready, busy, product_valid, product}, 32'd0);
`ifdef RADIX4_ACC_ERR_EN
    check("mid-run reset err", {31'd0, err}, 32'd0);
`endif
    step();
    reset = 1'b0;
    step();
    check("idle after mid-run reset", {30'd0, busy, product_valid}, 32'd0);
    run(vecs[0], 0, 0, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/radix4_pp_accumulator.md
# radix4_pp_accumulator

Downstream stage of the radix-4 serial recoder multiplier. Each cycle it consumes one selected partial product from the recoder/selector pair, accumulates it, and shifts the sum right two bit positions. After the last digit it folds in the recoder's final carry and presents the 2·WIDTH-bit unsigned product through a valid/ready handshake. It owns the digit count and the accumulate/complete sequencing for one multiplication.

## Interface
- WIDTH, 8: operand width; even, ≥4
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a new product; accepted only in IDLE
- x  in  WIDTH  multiplicand; captured on accepted start
- pp_valid  in  1  pp/pp_neg/final_carry valid this cycle
- pp_ready  out  1  high in ACCUM only; digit accepted when pp_valid&&pp_ready
- pp  in  WIDTH+2  selected partial product (0, x, ~x, 2x), sign-extended two's complement
- pp_neg  in  1  +1 carry-in completing negation of ~x
- final_carry  in  1  recoder carry-out; sampled only with the last digit
- busy  out  1  state ≠ IDLE
- product  out  2·WIDTH  result; stable while product_valid
- product_valid  out  1  result available
- product_ready  in  1  consumer accepts product

## Operation
- States: IDLE, ACCUM, CARRY, HOLD.
- IDLE: on start, capture x, clear acc (WIDTH+2 signed) and low (WIDTH bits), clear digit count, go to ACCUM.
- ACCUM: on each accepted digit, sum = sext(acc) + sext(pp) + pp_neg, computed at WIDTH+3 bits signed.
  - low <= {sum[1:0], low[WIDTH-1:2]}.
  - acc <= sum >>> 2, truncated to WIDTH+2.
  - count++.
  - The accepted digit with count == WIDTH/2−1 is the last one: latch final_carry and go to CARRY.
  - No acceptance leaves all state unchanged.
- CARRY: high = acc[WIDTH-1:0] + (fc ? x : 0), modulo 2^WIDTH. Register product = {high, low} and go to HOLD.
- HOLD: product_valid=1. On product_ready, go to IDLE and drop product_valid. product keeps its value until the next start.
- start outside IDLE is ignored. pp_valid outside ACCUM is ignored.
- Reset values: pp_ready=0, busy=0, product_valid=0, product=0. All internal registers are 0 and the state is IDLE.

## Timing
- Cycle 0: start accepted in IDLE. Cycle 1: pp_ready=1.
- With pp_valid held high, digits are accepted in cycles 1..WIDTH/2.
- CARRY occurs at WIDTH/2+1. product_valid rises at WIDTH/2+2.
- Latency from start to product_valid is WIDTH/2+2 cycles; gaps in pp_valid extend it 1:1.
- HOLD→IDLE transition is on the product_ready cycle. The earliest next start is the following cycle.
- Reset mid-operation aborts immediately, with no partial product emitted.

## Configuration
- RADIX4_ACC_ERR_EN defined: adds output err (1 bit), a sticky flag.
  - Set when pp_valid=1 outside ACCUM.
  - Set when start=1 outside IDLE.
  - Set when sum overflows WIDTH+2 signed range after the shift.
  - Cleared by reset or an accepted start. Reset value 0.
- Not defined: no err port and no checking logic. All other behaviour is identical.

## Structure
- Package radix4_mult_pkg holds:
  - state enum (IDLE, ACCUM, CARRY, HOLD)
  - DIGITS = WIDTH/2
  - counter width $clog2(DIGITS+1)
- Sub-module radix4_acc_datapath (acc/low registers, adder, shifter, carry fold). The FSM and counter stay in the top.

## Test plan
- WIDTH=8, x=0xFF, multiplier 0xFF. Digits: pp=0x300/pp_neg=1, then three pp=0, final_carry=1 → product=0xFE01 at cycle 6.
- x=0x03, multiplier 0x02. Digits: pp=0x006, three pp=0, final_carry=0 → product=0x0006.
- x=0x00, any digits (all pp=0) → product=0x0000; product_valid after exactly WIDTH/2+2 cycles.
- Hold product_ready=0 for 5 cycles and pulse start → product_valid stays 1, product stable, start ignored (err=1 with macro).
- Assert reset after 2 digits → all outputs 0, IDLE; next 0xFF×0xFF run still yields 0xFE01.
- Insert pp_valid=0 gaps between digits → result unchanged; latency grows by the gap count.
